flip_9bit: RTL and testbench

FLIP_9BIT -- requirements
Module: flip_9bit

---
 rtl/flip_pkg.sv | 29 ++
 rtl/flip_skid.sv | 74 +++++++
 rtl/flip_9bit.sv | 63 ++++++
 tb/tb_flip_9bit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/flip_pkg.sv
// Shared definitions for the sign-flip datapath: the operation encoding,
// the default magnitude width, and the helper that derives a result sign.
package flip_pkg;

    localparam int MAG_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_FLIP = 2'b00,
        OP_ABS  = 2'b01,
        OP_NABS = 2'b10,
        OP_PASS = 2'b11
    } flip_op_e;

    // Sign of the result for a given operand sign and operation; the
    // magnitude is never touched, so the sign is all that needs deciding.
    function automatic logic opSign(input logic signIn, input flip_op_e opSel);
        logic s;
        s = signIn;
        case (opSel)
            OP_FLIP: s = ~signIn;
            OP_ABS:  s = 1'b0;
            OP_NABS: s = 1'b1;
            OP_PASS: s = signIn;
            default: s = signIn;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/flip_skid.sv
// Two-entry skid buffer with valid/ready on both sides. The head entry
// drives the output directly, so a result appears one cycle after it is
// accepted into an empty buffer. Accepting is allowed whenever fewer than
// two entries are held, which means a stalled consumer never loses data.
module flip_skid #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inData,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    input  logic             outReady
);

    logic [1:0]       count;
    logic [WIDTH-1:0] headData;
    logic [WIDTH-1:0] tailData;
    logic             push;
    logic             pop;

    // Handshake qualifiers; reset holds the input side closed.
    always_comb begin
        inReady  = 1'b0;
        outValid = 1'b0;
        if (!rst) begin
            inReady = (count != 2'd2);
        end
        outValid = (count != 2'd0);
        push     = inValid && inReady;
        pop      = outValid && outReady;
    end

    // Occupancy and storage update. The head is always the oldest entry;
    // a simultaneous push and pop with one entry held replaces the head,
    // and a pop with two entries held shifts the tail forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            headData <= '0;
            tailData <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        headData <= inData;
                        count    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        headData <= inData;
                    end else if (push) begin
                        tailData <= inData;
                        count    <= 2'd2;
                    end else if (pop) begin
                        count    <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        headData <= tailData;
                        count    <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign outData = headData;

endmodule

// File: rtl/flip_9bit.sv
// Sign-magnitude sign manipulator with a registered valid/ready output.
// The sign bit is rewritten according to op (or always flipped when
// OP_FLIP_DEFAULT is nonzero); the magnitude passes through untouched.
// Optional build macro FLIP_9BIT_ZERO_NORM_EN: when defined, a zero
// magnitude always gets a positive sign, so negative zero never appears.
module flip_9bit
    import flip_pkg::*;
#(
    parameter int MAG_W           = MAG_W_DEFAULT,
    parameter int OP_FLIP_DEFAULT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [MAG_W:0] inputA,
    input  logic [1:0]     op,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [MAG_W:0] out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           neg_zero
);

    flip_op_e       effOp;
    logic           resultSign;
    logic [MAG_W:0] resultData;

    // Build the result word ahead of the buffer: choose the effective
    // operation, derive the new sign, and optionally normalise zero.
    always_comb begin
        effOp      = (OP_FLIP_DEFAULT != 0) ? OP_FLIP : flip_op_e'(op);
        resultSign = opSign(inputA[MAG_W], effOp);
`ifdef FLIP_9BIT_ZERO_NORM_EN
        if (inputA[MAG_W-1:0] == '0) begin
            resultSign = 1'b0;
        end
`endif
        resultData = {resultSign, inputA[MAG_W-1:0]};
    end

    flip_skid #(
        .WIDTH (MAG_W + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .inData   (resultData),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .outData  (out),
        .outValid (out_valid),
        .outReady (out_ready)
    );

    // Negative-zero flag follows the presented result and is only
    // meaningful alongside out_valid.
    always_comb begin
        neg_zero = 1'b0;
`ifndef FLIP_9BIT_ZERO_NORM_EN
        neg_zero = out_valid && out[MAG_W] && (out[MAG_W-1:0] == '0);
`endif
    end

endmodule

// File: tb/tb_flip_9bit.sv
// Self-checking bench for flip_9bit. Two instances share all inputs: one
// with the default always-flip behaviour and one that honours op. A queue
// of expected results models the buffer; every cycle the outputs are
// compared against the front of that queue.
module tb_flip_9bit;

    localparam int MAG_W = 8;

    logic           clk;
    logic           rst;
    logic [MAG_W:0] inputA;
    logic [1:0]     op;
    logic           inValid;
    logic           outReady;

    logic           inReadyF, outValidF, negZeroF;
    logic [MAG_W:0] outF;
    logic           inReadyO, outValidO, negZeroO;
    logic [MAG_W:0] outO;

    typedef struct {
        logic [MAG_W:0] expF;
        logic [MAG_W:0] expO;
    } exp_t;

    exp_t q[$];

    int checks;
    int fails;

    flip_9bit #(
        .MAG_W           (MAG_W),
        .OP_FLIP_DEFAULT (1)
    ) dutF (
        .clk       (clk),
        .rst       (rst),
        .inputA    (inputA),
        .op        (op),
        .in_valid  (inValid),
        .in_ready  (inReadyF),
        .out       (outF),
        .out_valid (outValidF),
        .out_ready (outReady),
        .neg_zero  (negZeroF)
    );

    flip_9bit #(
        .MAG_W           (MAG_W),
        .OP_FLIP_DEFAULT (0)
    ) dutO (
        .clk       (clk),
        .rst       (rst),
        .inputA    (inputA),
        .op        (op),
        .in_valid  (inValid),
        .in_ready  (inReadyO),
        .out       (outO),
        .out_valid (outValidO),
        .out_ready (outReady),
        .neg_zero  (negZeroO)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result from plain sign/magnitude arithmetic.
    function automatic logic [MAG_W:0] refResult(input logic [MAG_W:0] a,
                                                 input logic [1:0] o,
                                                 input bit honourOp);
        int mag;
        int sgn;
        int sel;
        mag = int'(a) % 256;
        sgn = int'(a) / 256;
        sel = honourOp ? int'(o) : 0;
        case (sel)
            0: sgn = 1 - sgn;
            1: sgn = 0;
            2: sgn = 1;
            default: sgn = sgn;
        endcase
`ifdef FLIP_9BIT_ZERO_NORM_EN
        if (mag == 0) sgn = 0;
`endif
        return 9'(sgn * 256 + mag);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [MAG_W:0] a,
                                 input logic [1:0] o, input logic r);
        inValid  = v;
        inputA   = a;
        op       = o;
        outReady = r;
    endtask

    // One cycle: drive inputs, compare outputs against the model, then
    // advance the model by whatever handshakes occur on the coming edge.
    task automatic runCycle(input logic v, input logic [MAG_W:0] a,
                            input logic [1:0] o, input logic r);
        bit   pushOk;
        exp_t e;
        applyStimulus(v, a, o, r);
        #1;
        checkOutput("out_valid_f", 32'(outValidF), 32'(q.size() != 0));
        checkOutput("out_valid_o", 32'(outValidO), 32'(q.size() != 0));
        checkOutput("in_ready_f", 32'(inReadyF), 32'(q.size() < 2));
        checkOutput("in_ready_o", 32'(inReadyO), 32'(q.size() < 2));
        if (q.size() != 0) begin
            checkOutput("out_f", 32'(outF), 32'(q[0].expF));
            checkOutput("out_o", 32'(outO), 32'(q[0].expO));
            checkOutput("neg_zero_f", 32'(negZeroF), 32'(q[0].expF == 9'h100));
            checkOutput("neg_zero_o", 32'(negZeroO), 32'(q[0].expO == 9'h100));
        end else begin
            checkOutput("neg_zero_idle_f", 32'(negZeroF), 32'd0);
        end
        pushOk = v && (q.size() < 2);
        if (r && q.size() != 0) void'(q.pop_front());
        if (pushOk) begin
            e.expF = refResult(a, o, 1'b0);
            e.expO = refResult(a, o, 1'b1);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, '0, 2'b00, 1'b0);

        // Reset state
        #3;
        checkOutput("rst_out_valid", 32'(outValidF), 32'd0);
        checkOutput("rst_out", 32'(outF), 32'd0);
        checkOutput("rst_neg_zero", 32'(negZeroF), 32'd0);
        checkOutput("rst_in_ready", 32'(inReadyF), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(inReadyF), 32'd1);

        // Directed: flip of +3 and -3
        runCycle(1'b1, 9'b000000011, 2'b00, 1'b1);
        checkOutput("flip_pos3", 32'(outF), 32'h103);
        runCycle(1'b1, 9'b100000011, 2'b00, 1'b1);
        checkOutput("flip_neg3", 32'(outF), 32'h003);

        // Directed: zero operand
        runCycle(1'b1, 9'h000, 2'b00, 1'b1);
`ifdef FLIP_9BIT_ZERO_NORM_EN
        checkOutput("zero_out", 32'(outF), 32'h000);
        checkOutput("zero_negz", 32'(negZeroF), 32'd0);
`else
        checkOutput("zero_out", 32'(outF), 32'h100);
        checkOutput("zero_negz", 32'(negZeroF), 32'd1);
`endif

        // Directed: ABS, NABS, PASS on 0x185
        runCycle(1'b1, 9'h185, 2'b01, 1'b1);
        checkOutput("abs_o", 32'(outO), 32'h085);
        checkOutput("abs_f", 32'(outF), 32'h085);
        runCycle(1'b1, 9'h185, 2'b10, 1'b1);
        checkOutput("nabs_o", 32'(outO), 32'h185);
        checkOutput("nabs_f", 32'(outF), 32'h085);
        runCycle(1'b1, 9'h185, 2'b11, 1'b1);
        checkOutput("pass_o", 32'(outO), 32'h185);
        checkOutput("pass_f", 32'(outF), 32'h085);
        runCycle(1'b0, 9'h000, 2'b00, 1'b1);

        // Backpressure: three operands offered while the consumer stalls
        runCycle(1'b1, 9'h011, 2'b11, 1'b0);
        runCycle(1'b1, 9'h122, 2'b11, 1'b0);
        checkOutput("bp_full", 32'(inReadyF), 32'd0);
        runCycle(1'b1, 9'h033, 2'b11, 1'b0);
        runCycle(1'b1, 9'h033, 2'b11, 1'b1);
        runCycle(1'b1, 9'h033, 2'b11, 1'b1);
        runCycle(1'b0, 9'h000, 2'b00, 1'b1);
        runCycle(1'b0, 9'h000, 2'b00, 1'b1);
        checkOutput("bp_drained", 32'(q.size()), 32'd0);

        // Reset with two entries held
        runCycle(1'b1, 9'h044, 2'b00, 1'b0);
        runCycle(1'b1, 9'h155, 2'b00, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(outValidF), 32'd0);
        checkOutput("midrst_out", 32'(outF), 32'd0);
        checkOutput("midrst_in_ready", 32'(inReadyF), 32'd0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            runCycle(1'b0, 9'h1ff, 2'b00, 1'b1);
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            runCycle(1'($urandom_range(0, 3) != 0), 9'($urandom),
                     2'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) begin
            runCycle(1'b0, 9'h000, 2'b00, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
